// File: rtl/gin_pkg.sv
// Shared GIN/GON bus definitions.
// Default bus geometry and the {enable, tag, value} packet field positions
// used by both the multicast (GIN) and the gather (GON) buses.
package gin_pkg;

  localparam int GIN_MASTER_NUMS = 14;
  localparam int GIN_ID_LEN      = 5;
  localparam int GIN_VALUE_LEN   = 32;

  // Packet layout for the default geometry: {enable, tag, value}
  localparam int ENABLE_BIT = GIN_VALUE_LEN + GIN_ID_LEN;
  localparam int TAG_MSB    = ENABLE_BIT - 1;
  localparam int TAG_LSB    = GIN_VALUE_LEN;
  localparam int VALUE_MSB  = GIN_VALUE_LEN - 1;
  localparam int VALUE_LSB  = 0;

  // Enable-bit position for a non-default geometry.
  function automatic int gin_enable_bit(input int id_len, input int value_len);
    return value_len + id_len;
  endfunction

endpackage

// File: rtl/gon_rr_arbiter.sv
// Round-robin arbiter for the GON gather bus.
// Combinational grant: first requester at or after rr_ptr, wrapping mod N.
// rr_ptr moves to one past the winner only when a grant is made and committed.
//  clk, rst      clock, async active-low reset (rr_ptr -> 0)
//  req[N]        requests
//  en            grant allowed this cycle
//  advance       commit the grant (move rr_ptr)
//  grant[N]      one-hot grant, zero when no grant
//  grant_idx     index of the winning requester
module gon_rr_arbiter #(
  parameter int N = 14,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cand;
  logic [IW-1:0] nxt_ptr;
  logic          found;

  // (p + o) mod N without relying on N being a power of two
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int o);
    int t;
    t = int'(p) + o;
    if (t >= N) t = t - N;
    return IW'(t);
  endfunction

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    cand      = '0;
    for (int o = 0; o < N; o++) begin
      cand = wrap_add(rr_ptr, o);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

  assign nxt_ptr = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);

  // Idle cycles leave the pointer alone so fairness counts grants, not time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         rr_ptr <= '0;
    else if (advance && en && found)  rr_ptr <= nxt_ptr;
  end

endmodule

// File: rtl/gon_gather_bus.sv
// GON gather bus: collects results from one row of PEs and forwards one
// tagged word per cycle toward the GON root through a registered
// valid/ready output stage. Each slot's tag comes from a scan-loaded ID.
//  clk, rst              clock, async active-low reset
//  pe_valid/pe_data      per-slot result requests (slot i = [i*VALUE_LEN +: VALUE_LEN])
//  pe_ready              one-hot grant; the granted word is taken this cycle
//  out_enable_tag_value  {enable, tag, value}, enable is the MSB
//  out_ready             downstream accepts the output word
//  set_id/id_scan_in     ID scan shift enable and chain input
//  id_scan_out           chain output (last slot's ID), feeds the next bus
module gon_gather_bus
  import gin_pkg::*;
#(
  parameter int MASTER_NUMS = GIN_MASTER_NUMS,
  parameter int ID_LEN      = GIN_ID_LEN,
  parameter int VALUE_LEN   = GIN_VALUE_LEN,
  parameter int MA_Y        = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [MASTER_NUMS-1:0]           pe_valid,
  input  logic [MASTER_NUMS*VALUE_LEN-1:0] pe_data,
  output logic [MASTER_NUMS-1:0]           pe_ready,
  output logic [ID_LEN+VALUE_LEN:0]        out_enable_tag_value,
  input  logic                             out_ready,
  input  logic                             set_id,
  input  logic [ID_LEN-1:0]                id_scan_in,
  output logic [ID_LEN-1:0]                id_scan_out
);

  localparam int EN_BIT = gin_enable_bit(ID_LEN, VALUE_LEN);
  localparam int PKT_W  = EN_BIT + 1;
  localparam int IW     = (MASTER_NUMS > 1) ? $clog2(MASTER_NUMS) : 1;

  logic [MASTER_NUMS-1:0][ID_LEN-1:0]    id_reg;
  logic [MASTER_NUMS-1:0][VALUE_LEN-1:0] pe_words;
  logic [PKT_W-1:0]                      out_q;
  logic [IW-1:0]                         grant_idx;
  logic                                  slot_free;
  logic                                  arb_en;
  logic                                  grant_any;

  assign pe_words = pe_data;

  // Output slot can take a word if empty or being drained this edge.
  // rst in the enable keeps pe_ready low while reset is held.
  assign slot_free = !out_q[EN_BIT] || out_ready;
  assign arb_en    = rst && !set_id && slot_free;

  gon_rr_arbiter #(.N(MASTER_NUMS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (pe_valid),
    .en        (arb_en),
    .advance   (1'b1),
    .grant     (pe_ready),
    .grant_idx (grant_idx)
  );

  assign grant_any = |pe_ready;

  // ID scan chain: slot 0 is nearest the input, last slot drives the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_reg <= '0;
    end else if (set_id) begin
      id_reg[0] <= id_scan_in;
      for (int i = 1; i < MASTER_NUMS; i++) id_reg[i] <= id_reg[i-1];
    end
  end

  assign id_scan_out = id_reg[MASTER_NUMS-1];

  // Output stage: refill on grant, otherwise drop enable when drained and
  // keep tag/value as they were.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               out_q         <= '0;
    else if (grant_any)     out_q         <= {1'b1, id_reg[grant_idx], pe_words[grant_idx]};
    else if (out_ready)     out_q[EN_BIT] <= 1'b0;
  end

  assign out_enable_tag_value = out_q;

  a_onehot_grant: assert property (@(posedge clk) disable iff (!rst) $onehot0(pe_ready))
    else $error("gon_gather_bus row %0d: pe_ready not one-hot", MA_Y);

  a_no_grant_in_scan: assert property (@(posedge clk) disable iff (!rst) !(set_id && grant_any))
    else $error("gon_gather_bus row %0d: grant during ID scan", MA_Y);

endmodule
